exu_forward_ctrl: RTL and testbench
===================================

Name: exu_forward_ctrl

Overview:
- Hazard/forwarding controller for the EXU operand-select datapath.
- Produces FORWARD_{rs1,rs2,csr_rs}_hazard/data_EXU from MEM/WB write-back info.
- Holds a GPR pending-load scoreboard, raises EXU stall on unresolved load-use hazards, and caps outstanding loads.

Parameters:
- MAX_OUTSTANDING, 2, maximum loads issued from EXU without a response (1..7).
- REG_NUM, 32, number of GPRs tracked; x0 is never pending.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- EXU_valid  in  1  valid instruction in EXU
- EXU_rs1  in  5  rs1 index
- EXU_rs2  in  5  rs2 index
- EXU_csr_rs  in  12  CSR read address
- EXU_use_rs1 / EXU_use_rs2 / EXU_use_csr  in  1 each  operand actually read
- EXU_rd  in  5  destination
- EXU_is_load  in  1  EXU instruction is a load
- EXU_fire  in  1  EXU instruction advances this cycle (valid & !stall & downstream ready)
- MEM_rd_we / MEM_rd / MEM_rd_data  in  1/5/32  MEM-stage GPR write (non-load results)
- MEM_csr_we / MEM_csr_addr / MEM_csr_data  in  1/12/32  MEM-stage CSR write
- WB_rd_we / WB_rd / WB_rd_data  in  1/5/32  WB-stage GPR write
- WB_csr_we / WB_csr_addr / WB_csr_data  in  1/12/32  WB-stage CSR write
- LSU_resp_valid / LSU_resp_rd / LSU_resp_data  in  1/5/32  load response
- FORWARD_rs1_hazard_EXU / FORWARD_rs1_data_EXU  out  1/32
- FORWARD_rs2_hazard_EXU / FORWARD_rs2_data_EXU  out  1/32
- FORWARD_csr_rs_hazard_EXU / FORWARD_csr_rs_data_EXU  out  1/32
- FORWARD_stall_EXU  out  1  hold EXU
- FORWARD_outstanding  out  3  current outstanding-load count

Behaviour:
- Reset (rst low, async):
  - Scoreboard pending[REG_NUM-1:0] and outstanding counter clear to 0.
  - With all inputs idle, every output reads 0.
  - A reset mid-operation discards in-flight loads. Any later response for a discarded load has no effect (clears nothing, count saturates at 0).
- Forwarding (combinational, zero latency):
  - GPR source s matches a stage when: stage we=1, stage rd==s, s!=0.
  - Priority order: MEM, then WB, then LSU response (bypass, see Optional Feature).
  - hazard=1 with that stage's data on the first match; otherwise hazard=0 and data=0.
  - CSR uses the same rule on MEM_csr/WB_csr with 12-bit address compare; CSR has no scoreboard.
- Scoreboard:
  - Set pending[EXU_rd] on EXU_fire & EXU_is_load & EXU_rd!=0.
  - Clear pending[LSU_resp_rd] on LSU_resp_valid.
  - Set and clear of the same index in the same cycle: set wins (newer load).
- Outstanding counter:
  - +1 on load fire, -1 on response; both in one cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING or drops below 0.
- Stall (combinational): FORWARD_stall_EXU = EXU_valid & (A | B | C).
  - A: used rs1 is pending and not forwarded this cycle.
  - B: same as A for rs2.
  - C: EXU_is_load and outstanding==MAX_OUTSTANDING and no response this cycle.
- State machine per EXU instruction:
  - RUN → HOLD when stall=1.
  - HOLD → RUN when the stall condition clears.
  - Registered bit FORWARD_hold_q; it only feeds the optional-feature timing.
- x0 is never forwarded, pending, or stalled on.

Optional Feature:
- Macro: FORWARD_RESP_BYPASS_EN.
- Defined:
  - LSU_resp data forwards to EXU in the response cycle (lowest priority).
  - The pending bit counts as resolved that cycle, so the stall drops immediately.
- Undefined:
  - Response only clears the scoreboard.
  - EXU remains stalled one extra cycle and picks up the value later via MEM/WB or the register file.

Decomposition:
- Package exu_forward_pkg:
  - REG_ADDR_W=5, CSR_ADDR_W=12, XLEN=32.
  - Typedef fwd_src_e {FWD_NONE, FWD_MEM, FWD_WB, FWD_RESP}.
  - Struct wb_port_t {we, addr, data}.
- Sub-module exu_forward_sel: one instance per operand, combinational priority match over the wb_port_t inputs.
- Top module holds scoreboard, counter, stall.

Test Plan:
1. MEM_rd_we=1, MEM_rd=5, data=0xDEAD_BEEF; WB_rd=5, data=0x1111; EXU_rs1=5 used → rs1 hazard=1, data=0xDEAD_BEEF (MEM wins), stall=0.
2. Load x7 fires. Next instruction uses rs2=7 → stall=1 each cycle until LSU_resp_valid, rd=7, data=0x42.
   - Bypass defined: hazard=1, data=0x42, stall=0 in that cycle.
   - Bypass undefined: stall for one more cycle.
3. MAX_OUTSTANDING=2: two loads fire with no response; third load → stall=1, outstanding=2. Response arrives → stall drops the same cycle and the count stays at 2 (one in, one out).
4. Load to x3 fires in the same cycle as a response for the older x3 load → pending[3] stays 1.
5. EXU_rs1=0 with MEM_rd=0, we=1 → hazard=0, no stall. CSR read 0x300 with WB_csr write 0x300, data=0x88 → csr hazard=1, data=0x88.
6. Assert rst low while 2 loads are pending → outstanding=0, pending cleared, stall=0 immediately. A stale response afterward leaves the count at 0.

Source files
------------

// File: rtl/exu_forward_ctrl_pkg.sv
// Shared types and widths for the EXU forwarding/hazard controller.
// Optional feature macro: FORWARD_RESP_BYPASS_EN (LSU response bypass).
package exu_forward_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_MEM,
    FWD_WB,
    FWD_RESP
  } fwd_src_e;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } fwd_state_e;

  // Generic write-back port; GPR addresses are zero-extended to CSR width.
  typedef struct packed {
    logic                  we;
    logic [CSR_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_port_t;

endpackage

// File: rtl/exu_forward_ctrl_if.sv
// EXU / MEM / WB / LSU signal bundle for the forwarding controller.
interface exu_forward_ctrl_if;
  import exu_forward_pkg::*;

  logic                  EXU_valid;
  logic [REG_ADDR_W-1:0] EXU_rs1;
  logic [REG_ADDR_W-1:0] EXU_rs2;
  logic [CSR_ADDR_W-1:0] EXU_csr_rs;
  logic                  EXU_use_rs1;
  logic                  EXU_use_rs2;
  logic                  EXU_use_csr;
  logic [REG_ADDR_W-1:0] EXU_rd;
  logic                  EXU_is_load;
  logic                  EXU_fire;

  logic                  MEM_rd_we;
  logic [REG_ADDR_W-1:0] MEM_rd;
  logic [XLEN-1:0]       MEM_rd_data;
  logic                  MEM_csr_we;
  logic [CSR_ADDR_W-1:0] MEM_csr_addr;
  logic [XLEN-1:0]       MEM_csr_data;

  logic                  WB_rd_we;
  logic [REG_ADDR_W-1:0] WB_rd;
  logic [XLEN-1:0]       WB_rd_data;
  logic                  WB_csr_we;
  logic [CSR_ADDR_W-1:0] WB_csr_addr;
  logic [XLEN-1:0]       WB_csr_data;

  logic                  LSU_resp_valid;
  logic [REG_ADDR_W-1:0] LSU_resp_rd;
  logic [XLEN-1:0]       LSU_resp_data;

  logic                  FORWARD_rs1_hazard_EXU;
  logic [XLEN-1:0]       FORWARD_rs1_data_EXU;
  logic                  FORWARD_rs2_hazard_EXU;
  logic [XLEN-1:0]       FORWARD_rs2_data_EXU;
  logic                  FORWARD_csr_rs_hazard_EXU;
  logic [XLEN-1:0]       FORWARD_csr_rs_data_EXU;
  logic                  FORWARD_stall_EXU;
  logic [2:0]            FORWARD_outstanding;

  modport master (
    output EXU_valid, EXU_rs1, EXU_rs2, EXU_csr_rs, EXU_use_rs1, EXU_use_rs2,
           EXU_use_csr, EXU_rd, EXU_is_load, EXU_fire,
           MEM_rd_we, MEM_rd, MEM_rd_data, MEM_csr_we, MEM_csr_addr, MEM_csr_data,
           WB_rd_we, WB_rd, WB_rd_data, WB_csr_we, WB_csr_addr, WB_csr_data,
           LSU_resp_valid, LSU_resp_rd, LSU_resp_data,
    input  FORWARD_rs1_hazard_EXU, FORWARD_rs1_data_EXU,
           FORWARD_rs2_hazard_EXU, FORWARD_rs2_data_EXU,
           FORWARD_csr_rs_hazard_EXU, FORWARD_csr_rs_data_EXU,
           FORWARD_stall_EXU, FORWARD_outstanding
  );

  modport slave (
    input  EXU_valid, EXU_rs1, EXU_rs2, EXU_csr_rs, EXU_use_rs1, EXU_use_rs2,
           EXU_use_csr, EXU_rd, EXU_is_load, EXU_fire,
           MEM_rd_we, MEM_rd, MEM_rd_data, MEM_csr_we, MEM_csr_addr, MEM_csr_data,
           WB_rd_we, WB_rd, WB_rd_data, WB_csr_we, WB_csr_addr, WB_csr_data,
           LSU_resp_valid, LSU_resp_rd, LSU_resp_data,
    output FORWARD_rs1_hazard_EXU, FORWARD_rs1_data_EXU,
           FORWARD_rs2_hazard_EXU, FORWARD_rs2_data_EXU,
           FORWARD_csr_rs_hazard_EXU, FORWARD_csr_rs_data_EXU,
           FORWARD_stall_EXU, FORWARD_outstanding
  );

endinterface

// File: rtl/exu_forward_sel.sv
// Per-operand priority forwarding match: MEM, then WB, then LSU response.
// SKIP_ZERO suppresses matches on address 0 (GPR x0).
module exu_forward_sel
  import exu_forward_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic [CSR_ADDR_W-1:0] src_addr,
  input  wb_port_t              mem_port,
  input  wb_port_t              wb_port,
  input  wb_port_t              resp_port,
  output fwd_src_e              src,
  output logic [XLEN-1:0]       data
);

  logic addr_ok;
  assign addr_ok = !(SKIP_ZERO && (src_addr == '0));

  // First matching stage wins; no match yields zero data.
  always_comb begin
    src  = FWD_NONE;
    data = '0;
    if (addr_ok) begin
      if (mem_port.we && (mem_port.addr == src_addr)) begin
        src  = FWD_MEM;
        data = mem_port.data;
      end else if (wb_port.we && (wb_port.addr == src_addr)) begin
        src  = FWD_WB;
        data = wb_port.data;
      end else if (resp_port.we && (resp_port.addr == src_addr)) begin
        src  = FWD_RESP;
        data = resp_port.data;
      end
    end
  end

endmodule

// File: rtl/exu_forward_ctrl.sv
// EXU hazard/forwarding controller: operand forwarding, GPR pending-load
// scoreboard, outstanding-load cap and EXU stall.
// Optional macro FORWARD_RESP_BYPASS_EN: forward LSU response data in the
// response cycle and treat the pending bit as resolved immediately.
module exu_forward_ctrl
  import exu_forward_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned REG_NUM         = 32
) (
  input logic               clk,
  input logic               rst,
  exu_forward_ctrl_if.slave bus
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic [REG_NUM-1:0]         pending;
  logic [2**REG_ADDR_W-1:0]   pending_ext;
  logic [2:0]                 outstanding;
  fwd_state_e                 state_q, state_d;
  logic                       FORWARD_hold_q;
  logic                       unused_hold;

  wb_port_t mem_gpr, wb_gpr, resp_gpr, mem_csr, wb_csr, no_port;
  fwd_src_e rs1_src, rs2_src, csr_src;

  logic load_fire, set_en, stall_a, stall_b, stall_c, stall;

  assign no_port = '0;

  assign mem_gpr.we   = bus.MEM_rd_we;
  assign mem_gpr.addr = CSR_ADDR_W'(bus.MEM_rd);
  assign mem_gpr.data = bus.MEM_rd_data;
  assign wb_gpr.we    = bus.WB_rd_we;
  assign wb_gpr.addr  = CSR_ADDR_W'(bus.WB_rd);
  assign wb_gpr.data  = bus.WB_rd_data;
`ifdef FORWARD_RESP_BYPASS_EN
  assign resp_gpr.we  = bus.LSU_resp_valid;
`else
  assign resp_gpr.we  = 1'b0;
`endif
  assign resp_gpr.addr = CSR_ADDR_W'(bus.LSU_resp_rd);
  assign resp_gpr.data = bus.LSU_resp_data;

  assign mem_csr.we   = bus.MEM_csr_we;
  assign mem_csr.addr = bus.MEM_csr_addr;
  assign mem_csr.data = bus.MEM_csr_data;
  assign wb_csr.we    = bus.WB_csr_we;
  assign wb_csr.addr  = bus.WB_csr_addr;
  assign wb_csr.data  = bus.WB_csr_data;

  exu_forward_sel #(.SKIP_ZERO(1'b1)) u_sel_rs1 (
    .src_addr  (CSR_ADDR_W'(bus.EXU_rs1)),
    .mem_port  (mem_gpr),
    .wb_port   (wb_gpr),
    .resp_port (resp_gpr),
    .src       (rs1_src),
    .data      (bus.FORWARD_rs1_data_EXU)
  );

  exu_forward_sel #(.SKIP_ZERO(1'b1)) u_sel_rs2 (
    .src_addr  (CSR_ADDR_W'(bus.EXU_rs2)),
    .mem_port  (mem_gpr),
    .wb_port   (wb_gpr),
    .resp_port (resp_gpr),
    .src       (rs2_src),
    .data      (bus.FORWARD_rs2_data_EXU)
  );

  exu_forward_sel #(.SKIP_ZERO(1'b0)) u_sel_csr (
    .src_addr  (bus.EXU_csr_rs),
    .mem_port  (mem_csr),
    .wb_port   (wb_csr),
    .resp_port (no_port),
    .src       (csr_src),
    .data      (bus.FORWARD_csr_rs_data_EXU)
  );

  assign bus.FORWARD_rs1_hazard_EXU    = (rs1_src != FWD_NONE);
  assign bus.FORWARD_rs2_hazard_EXU    = (rs2_src != FWD_NONE);
  assign bus.FORWARD_csr_rs_hazard_EXU = (csr_src != FWD_NONE);

  assign load_fire = bus.EXU_fire && bus.EXU_is_load;
  assign set_en    = load_fire && (bus.EXU_rd != '0);

  // Scoreboard: set on load fire, clear on response; set wins on collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int unsigned i = 1; i < REG_NUM; i++) begin
        if (set_en && (bus.EXU_rd == REG_ADDR_W'(i)))
          pending[i] <= 1'b1;
        else if (bus.LSU_resp_valid && (bus.LSU_resp_rd == REG_ADDR_W'(i)))
          pending[i] <= 1'b0;
      end
    end
  end

  // Outstanding-load counter, saturating at 0 and MAX_OUTSTANDING.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      if (load_fire && !(bus.LSU_resp_valid && (outstanding != '0))) begin
        if (outstanding != MAX_CNT)
          outstanding <= outstanding + 3'd1;
      end else if (!load_fire && bus.LSU_resp_valid && (outstanding != '0)) begin
        outstanding <= outstanding - 3'd1;
      end
    end
  end

  assign pending_ext = (2**REG_ADDR_W)'(pending);

  // A forward from any stage (including the bypassed response) resolves the pending bit.
  assign stall_a = bus.EXU_use_rs1 && pending_ext[bus.EXU_rs1] && !bus.FORWARD_rs1_hazard_EXU;
  assign stall_b = bus.EXU_use_rs2 && pending_ext[bus.EXU_rs2] && !bus.FORWARD_rs2_hazard_EXU;
  assign stall_c = bus.EXU_is_load && (outstanding == MAX_CNT) && !bus.LSU_resp_valid;
  assign stall   = bus.EXU_valid && (stall_a || stall_b || stall_c);

  assign bus.FORWARD_stall_EXU   = stall;
  assign bus.FORWARD_outstanding = outstanding;

  // RUN/HOLD state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Next state follows the stall condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (stall)  state_d = ST_HOLD;
      ST_HOLD: if (!stall) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign FORWARD_hold_q = (state_q == ST_HOLD);
  assign unused_hold    = FORWARD_hold_q;

endmodule

// File: tb/tb_exu_forward_ctrl.sv
// Directed self-checking bench for exu_forward_ctrl (MAX_OUTSTANDING=2).
module tb_exu_forward_ctrl;
  import exu_forward_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exu_forward_ctrl_if bus ();

  exu_forward_ctrl #(.MAX_OUTSTANDING(2), .REG_NUM(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.EXU_valid = 0; bus.EXU_rs1 = 0; bus.EXU_rs2 = 0; bus.EXU_csr_rs = 0;
    bus.EXU_use_rs1 = 0; bus.EXU_use_rs2 = 0; bus.EXU_use_csr = 0;
    bus.EXU_rd = 0; bus.EXU_is_load = 0; bus.EXU_fire = 0;
    bus.MEM_rd_we = 0; bus.MEM_rd = 0; bus.MEM_rd_data = 0;
    bus.MEM_csr_we = 0; bus.MEM_csr_addr = 0; bus.MEM_csr_data = 0;
    bus.WB_rd_we = 0; bus.WB_rd = 0; bus.WB_rd_data = 0;
    bus.WB_csr_we = 0; bus.WB_csr_addr = 0; bus.WB_csr_data = 0;
    bus.LSU_resp_valid = 0; bus.LSU_resp_rd = 0; bus.LSU_resp_data = 0;
  endtask

  // Advance to the next falling edge, where inputs are changed.
  task automatic next();
    @(negedge clk);
  endtask

  task automatic load_fire(input logic [4:0] rd);
    idle();
    bus.EXU_valid = 1; bus.EXU_is_load = 1; bus.EXU_rd = rd; bus.EXU_fire = 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b0;
    #12;
    // Reset state, all inputs idle
    chk("rst_stall",  32'(bus.FORWARD_stall_EXU), 32'd0);
    chk("rst_outst",  32'(bus.FORWARD_outstanding), 32'd0);
    chk("rst_rs1_hz", 32'(bus.FORWARD_rs1_hazard_EXU), 32'd0);
    chk("rst_csr_hz", 32'(bus.FORWARD_csr_rs_hazard_EXU), 32'd0);
    chk("rst_rs1_d",  bus.FORWARD_rs1_data_EXU, 32'd0);
    next();
    rst = 1'b1;

    // 1: MEM beats WB on rs1=5
    next();
    bus.EXU_valid = 1; bus.EXU_use_rs1 = 1; bus.EXU_rs1 = 5;
    bus.MEM_rd_we = 1; bus.MEM_rd = 5; bus.MEM_rd_data = 32'hDEAD_BEEF;
    bus.WB_rd_we = 1;  bus.WB_rd = 5;  bus.WB_rd_data = 32'h1111;
    #1;
    chk("t1_hz",    32'(bus.FORWARD_rs1_hazard_EXU), 32'd1);
    chk("t1_data",  bus.FORWARD_rs1_data_EXU, 32'hDEAD_BEEF);
    chk("t1_stall", 32'(bus.FORWARD_stall_EXU), 32'd0);
    chk("t1_rs2hz", 32'(bus.FORWARD_rs2_hazard_EXU), 32'd0);
    bus.MEM_rd_we = 0;
    #1;
    chk("t1_wb_data", bus.FORWARD_rs1_data_EXU, 32'h1111);

    // 2: load x7, consumer of rs2=7 stalls until the response
    next();
    load_fire(5'd7);
    next();
    idle();
    bus.EXU_valid = 1; bus.EXU_use_rs2 = 1; bus.EXU_rs2 = 7;
    #1;
    chk("t2_stall0", 32'(bus.FORWARD_stall_EXU), 32'd1);
    chk("t2_outst",  32'(bus.FORWARD_outstanding), 32'd1);
    chk("t2_hz0",    32'(bus.FORWARD_rs2_hazard_EXU), 32'd0);
    next();
    #1;
    chk("t2_stall1", 32'(bus.FORWARD_stall_EXU), 32'd1);
    next();
    bus.LSU_resp_valid = 1; bus.LSU_resp_rd = 7; bus.LSU_resp_data = 32'h42;
    #1;
`ifdef FORWARD_RESP_BYPASS_EN
    chk("t2_resp_hz",    32'(bus.FORWARD_rs2_hazard_EXU), 32'd1);
    chk("t2_resp_data",  bus.FORWARD_rs2_data_EXU, 32'h42);
    chk("t2_resp_stall", 32'(bus.FORWARD_stall_EXU), 32'd0);
`else
    chk("t2_resp_hz",    32'(bus.FORWARD_rs2_hazard_EXU), 32'd0);
    chk("t2_resp_data",  bus.FORWARD_rs2_data_EXU, 32'h0);
    chk("t2_resp_stall", 32'(bus.FORWARD_stall_EXU), 32'd1);
`endif
    next();
    bus.LSU_resp_valid = 0;
    #1;
    chk("t2_after_stall", 32'(bus.FORWARD_stall_EXU), 32'd0);
    chk("t2_after_outst", 32'(bus.FORWARD_outstanding), 32'd0);

    // 3: outstanding cap at 2
    next();
    load_fire(5'd1);
    next();
    load_fire(5'd2);
    next();
    idle();
    bus.EXU_valid = 1; bus.EXU_is_load = 1; bus.EXU_rd = 4;
    #1;
    chk("t3_cap_stall", 32'(bus.FORWARD_stall_EXU), 32'd1);
    chk("t3_cap_outst", 32'(bus.FORWARD_outstanding), 32'd2);
    bus.LSU_resp_valid = 1; bus.LSU_resp_rd = 1;
    #1;
    chk("t3_resp_stall", 32'(bus.FORWARD_stall_EXU), 32'd0);
    bus.EXU_fire = 1;
    next();
    idle();
    #1;
    chk("t3_inout_outst", 32'(bus.FORWARD_outstanding), 32'd2);
    bus.LSU_resp_valid = 1; bus.LSU_resp_rd = 2;
    next();
    bus.LSU_resp_rd = 4;
    next();
    idle();
    #1;
    chk("t3_drain_outst", 32'(bus.FORWARD_outstanding), 32'd0);

    // 4: new load to x3 collides with response for older x3 load
    next();
    load_fire(5'd3);
    next();
    load_fire(5'd3);
    bus.LSU_resp_valid = 1; bus.LSU_resp_rd = 3;
    next();
    idle();
    bus.EXU_valid = 1; bus.EXU_use_rs1 = 1; bus.EXU_rs1 = 3;
    #1;
    chk("t4_pend3_stall", 32'(bus.FORWARD_stall_EXU), 32'd1);
    chk("t4_outst",       32'(bus.FORWARD_outstanding), 32'd1);

    // 5: x0 never forwarded; CSR forwarding from WB then MEM
    next();
    idle();
    bus.EXU_valid = 1; bus.EXU_use_rs1 = 1; bus.EXU_rs1 = 0;
    bus.MEM_rd_we = 1; bus.MEM_rd = 0; bus.MEM_rd_data = 32'h5;
    bus.EXU_use_csr = 1; bus.EXU_csr_rs = 12'h300;
    bus.WB_csr_we = 1; bus.WB_csr_addr = 12'h300; bus.WB_csr_data = 32'h88;
    bus.MEM_csr_we = 1; bus.MEM_csr_addr = 12'h301; bus.MEM_csr_data = 32'h99;
    #1;
    chk("t5_x0_hz",    32'(bus.FORWARD_rs1_hazard_EXU), 32'd0);
    chk("t5_x0_data",  bus.FORWARD_rs1_data_EXU, 32'd0);
    chk("t5_x0_stall", 32'(bus.FORWARD_stall_EXU), 32'd0);
    chk("t5_csr_hz",   32'(bus.FORWARD_csr_rs_hazard_EXU), 32'd1);
    chk("t5_csr_data", bus.FORWARD_csr_rs_data_EXU, 32'h88);
    bus.MEM_csr_addr = 12'h300;
    #1;
    chk("t5_csr_mem",  bus.FORWARD_csr_rs_data_EXU, 32'h99);

    // 6: async reset with two loads in flight, then a stale response
    next();
    load_fire(5'd9);
    next();
    idle();
    bus.EXU_valid = 1; bus.EXU_use_rs1 = 1; bus.EXU_rs1 = 3;
    #1;
    chk("t6_pre_outst", 32'(bus.FORWARD_outstanding), 32'd2);
    chk("t6_pre_stall", 32'(bus.FORWARD_stall_EXU), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_outst", 32'(bus.FORWARD_outstanding), 32'd0);
    chk("t6_rst_stall", 32'(bus.FORWARD_stall_EXU), 32'd0);
    next();
    rst = 1'b1;
    next();
    idle();
    bus.LSU_resp_valid = 1; bus.LSU_resp_rd = 3;
    next();
    idle();
    bus.EXU_valid = 1; bus.EXU_use_rs1 = 1; bus.EXU_rs1 = 9;
    #1;
    chk("t6_stale_outst", 32'(bus.FORWARD_outstanding), 32'd0);
    chk("t6_stale_stall", 32'(bus.FORWARD_stall_EXU), 32'd0);

    next();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
